// File: rtl/rv32_cpu_cp_sequencer.sv
// Co-processor sequencer: issues one op to a selected ALU co-processor, waits for its valid
// (with timeout and trap abort), and returns the latched result. Optional macro: CP_SEQ_PERF_EN.
module rv32_cpu_cp_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_CP  = 5,
  parameter int unsigned TMO_MAX = 255,
  parameter int unsigned TMO_W   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_issue,
  input  logic [2:0]               i_cp_sel,
  input  logic [NUM_CP-1:0]        i_cp_present,
  input  logic                     i_trap,
  output logic                     o_ready,
  output logic [NUM_CP-1:0]        o_cp_start,
  output logic                     o_cp_abort,
  input  logic [NUM_CP-1:0]        i_cp_valid,
  input  logic [NUM_CP*XLEN-1:0]   i_cp_result,
  output logic                     o_done,
  output logic                     o_err,
`ifdef CP_SEQ_PERF_EN
  output logic [31:0]              o_perf_busy,
`endif
  output logic [XLEN-1:0]          o_res
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned SLOTS = 1 << SEL_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CP-1:0] start_q, start_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic [SLOTS-1:0]  present_ext;
  logic              sel_ok;
  logic              slot_valid;
  logic [XLEN-1:0]   slot_res;

  // Target legality and selected-slot valid/result mux
  always_comb begin
    present_ext = SLOTS'(i_cp_present);
    sel_ok      = (32'(i_cp_sel) < NUM_CP) && present_ext[i_cp_sel];
    slot_valid  = 1'b0;
    slot_res    = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      if (sel_q == SEL_W'(k)) begin
        slot_valid = i_cp_valid[k];
        slot_res   = i_cp_result[k*XLEN +: XLEN];
      end
    end
  end

  // Next-state and registered-output logic; trap overrides everything but reset
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    start_d = '0;
    abort_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    res_d   = res_q;
    if (i_trap) begin
      state_d = S_IDLE;
      abort_d = (state_q == S_START) || (state_q == S_WAIT);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_issue) begin
            if (sel_ok) begin
              sel_d   = i_cp_sel;
              state_d = S_START;
              for (int k = 0; k < NUM_CP; k++) begin
                start_d[k] = (i_cp_sel == SEL_W'(k));
              end
            end else begin
              res_d   = '0;
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (slot_valid) begin
            res_d   = slot_res;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == TMO_W'(TMO_MAX)) begin
            res_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + TMO_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      start_q <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

`ifdef CP_SEQ_PERF_EN
  // Busy-cycle counter; free-running wrap, cleared only by reset
  logic [31:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q + 32'(state_q != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign o_perf_busy = busy_q;
`endif

  assign o_ready    = (state_q == S_IDLE);
  assign o_cp_start = start_q;
  assign o_cp_abort = abort_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_res      = res_q;

endmodule

// File: tb/tb_rv32_cpu_cp_sequencer.sv
// Directed self-checking bench for rv32_cpu_cp_sequencer (TMO_MAX=4).
module tb_rv32_cpu_cp_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue;
  logic [2:0]   sel;
  logic [4:0]   present;
  logic         trap;
  logic         ready;
  logic [4:0]   cp_start;
  logic         abort;
  logic [4:0]   valid;
  logic [159:0] result;
  logic         done;
  logic         err;
  logic [31:0]  res;
`ifdef CP_SEQ_PERF_EN
  logic [31:0]  perf_busy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_cpu_cp_sequencer #(.XLEN(32), .NUM_CP(5), .TMO_MAX(4), .TMO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_issue(issue), .i_cp_sel(sel),
    .i_cp_present(present), .i_trap(trap), .o_ready(ready),
    .o_cp_start(cp_start), .o_cp_abort(abort), .i_cp_valid(valid),
    .i_cp_result(result), .o_done(done), .o_err(err),
`ifdef CP_SEQ_PERF_EN
    .o_perf_busy(perf_busy),
`endif
    .o_res(res)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; sel = 3'd0; present = 5'b11111; trap = 1'b0;
    valid = 5'b0; result = '0;
    step(); step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_start", 32'(cp_start), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res", res, 32'd0);
    rst = 1'b0;
    step();

    // Normal op on slot 0, valid two cycles after start
    issue = 1'b1; sel = 3'd0;
    step();
    chk("t1_start", 32'(cp_start), 32'h01);
    chk("t1_ready_busy", 32'(ready), 32'd0);
    issue = 1'b0;
    step();
    chk("t1_start_off", 32'(cp_start), 32'h00);
    step();
    valid[0] = 1'b1; result[0 +: 32] = 32'h0000_00F0;
    chk("t1_no_done_yet", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_res", res, 32'h0000_00F0);
    valid = 5'b0;
    step();
    chk("t1_ready", 32'(ready), 32'd1);
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_res_hold", res, 32'h0000_00F0);

    // Absent target: straight to DONE with error
    present = 5'b00011; issue = 1'b1; sel = 3'd2;
    step();
    issue = 1'b0;
    chk("t2_no_start", 32'(cp_start), 32'd0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_res", res, 32'd0);
    step();
    chk("t2_ready", 32'(ready), 32'd1);
    chk("t2_done_off", 32'(done), 32'd0);
    present = 5'b11111;

    // Out-of-range select (>= NUM_CP) is also illegal
    issue = 1'b1; sel = 3'd6;
    step();
    issue = 1'b0;
    chk("t2b_done", 32'(done), 32'd1);
    chk("t2b_err", 32'(err), 32'd1);
    step();

    // Timeout: 5 WAIT cycles with TMO_MAX=4
    issue = 1'b1; sel = 3'd1;
    step();
    issue = 1'b0;
    chk("t3_start", 32'(cp_start), 32'h02);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_wait_no_done", 32'(done), 32'd0);
    end
    step();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_res", res, 32'd0);
    step();
    chk("t3_ready", 32'(ready), 32'd1);

    // Non-selected valid ignored; issue during WAIT ignored
    valid[0] = 1'b1; result[0 +: 32] = 32'h1111_1111; result[64 +: 32] = 32'hDEAD_BEEF;
    issue = 1'b1; sel = 3'd2;
    step();
    chk("t5_start", 32'(cp_start), 32'h04);
    issue = 1'b0;
    step();
    issue = 1'b1; sel = 3'd0;
    step();
    chk("t5_no_done", 32'(done), 32'd0);
    chk("t5_busy", 32'(ready), 32'd0);
    chk("t5_no_restart", 32'(cp_start), 32'd0);
    valid[2] = 1'b1;
    step();
    issue = 1'b0;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_res", res, 32'hDEAD_BEEF);
    valid = 5'b0;
    step();
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_start_idle", 32'(cp_start), 32'd0);

    // Trap in 2nd WAIT cycle
    issue = 1'b1; sel = 3'd1;
    step();
    issue = 1'b0;
    step();
    step();
    trap = 1'b1;
    step();
    trap = 1'b0;
    chk("t4_abort", 32'(abort), 32'd1);
    chk("t4_no_done", 32'(done), 32'd0);
    chk("t4_ready", 32'(ready), 32'd1);
    chk("t4_res", res, 32'hDEAD_BEEF);
    step();
    chk("t4_abort_off", 32'(abort), 32'd0);
    chk("t4_done_off", 32'(done), 32'd0);
    chk("t4_res_hold", res, 32'hDEAD_BEEF);

    // Trap beats a simultaneous valid: result not captured
    result[32 +: 32] = 32'h5555_AAAA;
    issue = 1'b1; sel = 3'd1;
    step();
    issue = 1'b0;
    step();
    valid[1] = 1'b1; trap = 1'b1;
    step();
    valid = 5'b0; trap = 1'b0;
    chk("t6_abort", 32'(abort), 32'd1);
    chk("t6_no_done", 32'(done), 32'd0);
    chk("t6_res", res, 32'hDEAD_BEEF);
    step();

`ifdef CP_SEQ_PERF_EN
    // Two back-to-back 4-cycle ops from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("perf_rst", perf_busy, 32'd0);
    valid[0] = 1'b1; result[0 +: 32] = 32'h0000_0001; sel = 3'd0;
    for (int n = 0; n < 2; n++) begin
      issue = 1'b1;
      step();
      issue = 1'b0;
      step();
      step();
      chk("perf_done", 32'(done), 32'd1);
      step();
    end
    valid = 5'b0;
    chk("perf_busy", perf_busy, 32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
